// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter giving two requesters one outstanding access to a data memory port; define DMEM_ARB_TIMEOUT_EN to abort reads whose m_ready never arrives
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif
module dmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [1:0]           size0,
  input  logic [`ADDR_SIZE:0]  addr0,
  input  logic [`INSTR_SIZE:0] wdata0,
  output logic                 gnt0,
  output logic                 done0,
  output logic [`INSTR_SIZE:0] rdata0,
  output logic                 err0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [1:0]           size1,
  input  logic [`ADDR_SIZE:0]  addr1,
  input  logic [`INSTR_SIZE:0] wdata1,
  output logic                 gnt1,
  output logic                 done1,
  output logic [`INSTR_SIZE:0] rdata1,
  output logic                 err1,
  output logic [`ADDR_SIZE:0]  m_addr,
  output logic                 m_r_enable,
  output logic                 m_w_enable,
  output logic [1:0]           m_w_size,
  output logic [`INSTR_SIZE:0] m_w_data,
  input  logic [`INSTR_SIZE:0] m_r_data,
  input  logic                 m_ready
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t st, nxt;
  logic last_grant, owner, we_q, done_q, err_q, tmo, fin;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("TIMEOUT_CYCLES must be at least 1");
  end
`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tmo = st == S_WAIT && !m_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  // count WAIT cycles, restarting from zero on every entry into WAIT
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= st == S_WAIT ? cnt + CW'(1) : '0;
  // error flag travels with the done pulse of an aborted read
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_q <= 1'b0;
    else err_q <= tmo;
`else
  assign tmo = 1'b0;
  assign err_q = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= S_IDLE;
    else st <= nxt;
  // next state: grant -> ISSUE; writes finish in ISSUE, reads wait for m_ready (or timeout)
  always_comb begin
    nxt = st == S_IDLE  ? ((gnt0 || gnt1) ? S_ISSUE : S_IDLE) :
          st == S_ISSUE ? (we_q ? S_IDLE : S_WAIT) :
          fin ? S_IDLE : S_WAIT;
  end
  // outputs: grants are combinational in IDLE, a tie goes to the port not granted last
  always_comb begin
    gnt0 = reset && st == S_IDLE && req0 && (!req1 || last_grant);
    gnt1 = reset && st == S_IDLE && req1 && (!req0 || !last_grant);
    m_w_enable = st == S_ISSUE && we_q;
    m_r_enable = st == S_ISSUE && !we_q;
    done0 = done_q && !owner;
    done1 = done_q && owner;
    err0 = err_q && !owner;
    err1 = err_q && owner;
    fin = st == S_WAIT && (m_ready || tmo);
  end
  // latch the winner's payload at grant, pulse done and capture read data at completion
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_grant <= 1'b1;
      owner <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      m_addr <= '0;
      m_w_size <= '0;
      m_w_data <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      done_q <= (st == S_ISSUE && we_q) || fin;
      if (gnt0 || gnt1) begin
        last_grant <= gnt1;
        owner <= gnt1;
        we_q <= gnt1 ? we1 : we0;
        m_addr <= gnt1 ? addr1 : addr0;
        m_w_size <= gnt1 ? size1 : size0;
        m_w_data <= gnt1 ? wdata1 : wdata0;
      end
      if (fin && owner) rdata1 <= tmo ? '0 : m_r_data;
      if (fin && !owner) rdata0 <= tmo ? '0 : m_r_data;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8, number of WAIT cycles without ready before the read is aborted (used only with DMEM_ARB_TIMEOUT_EN).
REQ-002 One clock and one reset: clk is the single clock; reset is asynchronous and active-low.
REQ-003 Clock port: clk, input, 1 bit, rising-edge clock for all state.
REQ-004 Reset port: reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-005 Requester ports, n = 0 (core LSU) and n = 1 (DMA/loader):
- reqn, input, 1 bit, request pending.
- wen, input, 1 bit, 1 = write, 0 = read.
- sizen, input, 2 bits, 00 = byte, 01 = half, 10 = word.
- addrn, input, `ADDR_SIZE+1 bits, byte address.
- wdatan, input, `INSTR_SIZE+1 bits, write data.
- gntn, output, 1 bit, one-cycle acceptance pulse.
- donen, output, 1 bit, one-cycle completion pulse.
- rdatan, output, `INSTR_SIZE+1 bits, read data, valid while donen=1.
- errn, output, 1 bit, read timed out, valid while donen=1.
REQ-006 Memory-side ports:
- m_addr, output, `ADDR_SIZE+1 bits.
- m_r_enable, output, 1 bit.
- m_w_enable, output, 1 bit.
- m_w_size, output, 2 bits.
- m_w_data, output, `INSTR_SIZE+1 bits.
- m_r_data, input, `INSTR_SIZE+1 bits.
- m_ready, input, 1 bit, asserted one cycle after m_r_enable.

Function
REQ-007 FSM states are IDLE, ISSUE and WAIT; at most one transaction is outstanding.
REQ-008 IDLE arbitration:
- If any reqn=1, the winner's gntn is driven combinationally high for that cycle.
- On that edge the winner's we, size, addr and wdata are latched and the state moves to ISSUE.
REQ-009 Arbitration is round-robin: when both requesters are active, the port not granted last wins. A last_grant register holds this and resets to port 1, so port 0 wins the first tie.
REQ-010 A single requester wins regardless of last_grant; gnt0 and gnt1 are never high together.
REQ-011 Requester rule:
- Hold reqn and payload stable until gntn.
- A req still high in the cycle after gnt is a new request.
- Dropping req before gnt withdraws it without side effects.
REQ-012 ISSUE drives m_addr, m_w_size and m_w_data from the latched values for exactly one cycle.
- Write: m_w_enable=1; then the state returns to IDLE and donen pulses in the next cycle.
- Read: m_r_enable=1; then the state moves to WAIT.
REQ-013 WAIT behaviour:
- m_addr stays held and m_r_enable=0.
- When m_ready=1, m_r_data is registered into rdatan, donen pulses in the next cycle, and the state returns to IDLE.
REQ-014 Latency from gnt cycle T0: write done at T2; read (m_ready at T2) done at T3 with data.
REQ-015 A new grant may occur in the same cycle a donen pulse is shown, giving back-to-back writes every 2 cycles.
REQ-016 Outside ISSUE, m_r_enable and m_w_enable are 0.
REQ-017 Outside WAIT/ISSUE, m_addr, m_w_size and m_w_data hold their last values.
REQ-018 rdatan holds its last value between transactions.
REQ-019 Only the port owning the transaction sees donen, rdatan or errn change.
REQ-020 An m_ready arriving in IDLE or ISSUE is ignored.

Reset
REQ-021 On reset=0, asynchronously clear all of the following:
- state to IDLE and last_grant to 1;
- gnt, done, err, m_r_enable and m_w_enable to 0;
- m_addr, m_w_size, m_w_data, rdata and the timeout counter to 0.
REQ-022 Reset mid-transaction drops it: no done is issued and no memory enable is asserted until a new grant after reset is released.

Configuration
REQ-023 Macro DMEM_ARB_TIMEOUT_EN, when defined, adds a WAIT cycle counter.
- If TIMEOUT_CYCLES WAIT cycles elapse with m_ready=0, the read is aborted: donen=1, errn=1, rdatan=0, state returns to IDLE.
- A late m_ready is then ignored.
REQ-024 Without DMEM_ARB_TIMEOUT_EN, WAIT lasts until m_ready, errn is tied 0, and no counter is synthesized.

Verification
REQ-025 Reset: reset=0 with both reqs high -> no gnt, all outputs 0; release -> gnt0 first.
REQ-026 Port 0 write, addr=0x10, wdata=0xDEADBEEF, size=10 -> m_w_enable at T1 with those values; done0 at T2; done1 stays 0.
REQ-027 Port 1 read, addr=0x10, model returns 0xDEADBEEF with m_ready at T2 -> done1 and rdata1=0xDEADBEEF at T3, err1=0.
REQ-028 Both ports request continuously, 4 reads -> grants alternate 0,1,0,1; never simultaneous.
REQ-029 With DMEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, m_ready withheld -> done0=1, err0=1, rdata0=0 after 8 WAIT cycles; a later m_ready is ignored.
REQ-030 reset asserted in WAIT -> no done ever issued for that read; next request after release completes normally.
